// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Control FSM for the multicycle RV32I core. Each instruction is stepped
// through a short sequence of states (FETCH, DECODE, then 1-3 execution
// states), and every datapath select is driven from here. The shared
// instruction/data memory is handshaked through mem_ready. An unsupported
// opcode, or an unsupported funct3 on a branch or jalr, parks the FSM in
// TRAP with illegal raised until reset.
//
// Parameters:
//   RESET_TRAP  1 = illegal survives reset (debug builds), 0 = reset clears it
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   op          in   instr[6:0]
//   funct3      in   instr[14:12]
//   funct7b5    in   instr[30]
//   zero        in   ALU result == 0
//   lt          in   signed A < B
//   ltu         in   unsigned A < B
//   mem_ready   in   memory has completed the current access
//   pcwrite     out  PC load enable
//   adrsrc      out  memory address select (0 PC, 1 ALUOut)
//   memwrite    out  data write strobe
//   irwrite     out  IR / oldPC load enable
//   regwrite    out  register file write enable
//   resultsrc   out  result select (00 ALUOut, 01 mem data, 10 ALU result)
//   alusrca     out  ALU A select (00 PC, 01 oldPC, 10 rs1, 11 zero)
//   alusrcb     out  ALU B select (00 rs2, 01 immext, 10 constant 4)
//   alucontrol  out  ALU operation code
//   immsrc      out  immediate format (000 I, 001 S, 010 B, 011 J, 100 U)
//   illegal     out  trap flag
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter bit RESET_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] alucontrol,
  output logic [2:0] immsrc,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_JALLINK,
    S_LUI, S_AUIPC, S_TRAP
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;

  logic       w_pcwrite;
  logic       w_memwrite;
  logic       w_irwrite;
  logic       w_regwrite;
  logic       w_taken;
  logic       w_branchBad;

  // Map funct3/funct7b5 to an ALU operation. Immediate ops never subtract,
  // because instr[30] is part of the immediate for addi; only the shift
  // group looks at funct7b5 there.
  function automatic logic [3:0] aluDecode(input logic [2:0] f3,
                                           input logic       f7b5,
                                           input logic       isImm);
    logic [3:0] res;
    case (f3)
      3'b000:  res = (f7b5 && !isImm) ? ALU_SUB : ALU_ADD;
      3'b001:  res = ALU_SLL;
      3'b010:  res = ALU_SLT;
      3'b011:  res = ALU_SLTU;
      3'b100:  res = ALU_XOR;
      3'b101:  res = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  res = ALU_OR;
      default: res = ALU_AND;
    endcase
    return res;
  endfunction

  // State register and sticky trap flag. The trap flag is raised as the FSM
  // enters TRAP, so illegal is already high in the first TRAP cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      if (!RESET_TRAP) begin
        r_illegal <= 1'b0;
      end
    end else begin
      r_state <= w_next;
      if (w_next == S_TRAP) begin
        r_illegal <= 1'b1;
      end
    end
  end

  // Branch condition from funct3. Encodings 010/011 do not exist and are
  // flagged so the BRANCH state can trap instead of updating the PC.
  always_comb begin
    w_taken     = 1'b0;
    w_branchBad = 1'b0;
    case (funct3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = !zero;
      3'b100:  w_taken = lt;
      3'b101:  w_taken = !lt;
      3'b110:  w_taken = ltu;
      3'b111:  w_taken = !ltu;
      default: w_branchBad = 1'b1;
    endcase
  end

  // Immediate format follows the opcode directly so the extender output is
  // already valid while DECODE computes the branch/jal target.
  always_comb begin
    case (op)
      OP_STORE:         immsrc = 3'b001;
      OP_BRANCH:        immsrc = 3'b010;
      OP_JAL:           immsrc = 3'b011;
      OP_LUI, OP_AUIPC: immsrc = 3'b100;
      default:          immsrc = 3'b000;
    endcase
  end

  // Next-state and output decode. Everything defaults to 0/add so each
  // state only lists the selects it actually uses.
  always_comb begin
    w_next     = r_state;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_regwrite = 1'b0;
    adrsrc     = 1'b0;
    resultsrc  = 2'b00;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    alucontrol = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        w_irwrite  = mem_ready;
        w_pcwrite  = mem_ready;
        if (mem_ready) begin
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR;
          OP_LUI:            w_next = S_LUI;
          OP_AUIPC:          w_next = S_AUIPC;
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        w_next  = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) begin
          w_next = S_MEMWB;
        end
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc     = 1'b1;
        w_memwrite = 1'b1;
        if (mem_ready) begin
          w_next = S_FETCH;
        end
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        alucontrol = aluDecode(funct3, funct7b5, 1'b0);
        w_next     = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        alucontrol = aluDecode(funct3, funct7b5, 1'b1);
        w_next     = S_ALUWB;
      end
      S_ALUWB: begin
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 2'b10;
        alucontrol = ALU_SUB;
        w_pcwrite  = w_taken && !w_branchBad;
        w_next     = w_branchBad ? S_TRAP : S_FETCH;
      end
      S_JAL: begin
        alusrca   = 2'b01;
        alusrcb   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_JALR: begin
        alusrca   = 2'b10;
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = (funct3 == 3'b000) ? S_JALLINK : S_TRAP;
      end
      S_JALLINK: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        w_regwrite = 1'b1;
        w_next     = S_FETCH;
      end
      S_LUI: begin
        alusrca = 2'b11;
        alusrcb = 2'b01;
        w_next  = S_ALUWB;
      end
      S_AUIPC: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        w_next  = S_ALUWB;
      end
      default: begin
        w_next = S_TRAP;
      end
    endcase
  end

  // Strobes are forced low whenever reset is asserted, so an instruction
  // interrupted by reset never gets a partial write out of its current state.
  assign pcwrite  = w_pcwrite  & rst_n;
  assign memwrite = w_memwrite & rst_n;
  assign irwrite  = w_irwrite  & rst_n;
  assign regwrite = w_regwrite & rst_n;
  assign illegal  = r_illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Directed bench for the multicycle control FSM. A table of per-cycle
// {inputs, expected outputs} records walks the FSM through reset, fetch
// wait states, load, store with memory wait, R/I-type ALU decode, taken and
// not-taken branches, jal and an illegal opcode. Hand-written sequences then
// cover reset in the middle of a store and a load whose read waits on memory.
// Outputs are compared at the falling edge; inputs change 1 ns after the
// rising edge.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       lt;
  logic       ltu;
  logic       mem_ready;
  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic       regwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [3:0] alucontrol;
  logic [2:0] immsrc;
  logic       illegal;

  int total;
  int bad;

  multicycle_controller #(.RESET_TRAP(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .lt         (lt),
    .ltu        (ltu),
    .mem_ready  (mem_ready),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .alucontrol (alucontrol),
    .immsrc     (immsrc),
    .illegal    (illegal)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output bundle: {pcwrite, adrsrc, memwrite, irwrite, regwrite,
  // resultsrc[1:0], alusrca[1:0], alusrcb[1:0], alucontrol[3:0],
  // immsrc[2:0], illegal}
  logic [18:0] actOut;
  assign actOut = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                   alusrca, alusrcb, alucontrol, immsrc, illegal};

  typedef struct {
    logic        rstN;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        zero;
    logic        lt;
    logic        ltu;
    logic        memReady;
    logic [18:0] expOut;
  } vec_t;

  vec_t vecs[$];

  // Expected output builders, one per FSM state, written from the
  // datapath-select table of the controller.
  function automatic logic [18:0] mk(logic pc, logic adr, logic mw, logic ir,
                                     logic rw, logic [1:0] res, logic [1:0] a,
                                     logic [1:0] b, logic [3:0] alu,
                                     logic [2:0] imm, logic ill);
    return {pc, adr, mw, ir, rw, res, a, b, alu, imm, ill};
  endfunction

  function automatic logic [18:0] stFetch(logic mr, logic [2:0] imm);
    return mk(mr, 0, 0, mr, 0, 2'b10, 2'b00, 2'b10, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stDecode(logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stMemAdr(logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stMemRead(logic [2:0] imm);
    return mk(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stMemWb(logic [2:0] imm);
    return mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stMemWrite(logic [2:0] imm);
    return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stExecR(logic [3:0] alu, logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, alu, imm, 0);
  endfunction
  function automatic logic [18:0] stExecI(logic [3:0] alu, logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, alu, imm, 0);
  endfunction
  function automatic logic [18:0] stAluWb(logic [2:0] imm);
    return mk(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stBranch(logic taken, logic [2:0] imm);
    return mk(taken, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 4'd1, imm, 0);
  endfunction
  function automatic logic [18:0] stJal(logic [2:0] imm);
    return mk(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 4'd0, imm, 0);
  endfunction
  function automatic logic [18:0] stTrap(logic [2:0] imm);
    return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'd0, imm, 1);
  endfunction

  function automatic void addVec(logic rstN, logic [6:0] o, logic [2:0] f3,
                                 logic f7b5, logic z, logic l, logic lu,
                                 logic mr, logic [18:0] e);
    vec_t v;
    v.rstN = rstN; v.op = o; v.f3 = f3; v.f7b5 = f7b5;
    v.zero = z; v.lt = l; v.ltu = lu; v.memReady = mr; v.expOut = e;
    vecs.push_back(v);
  endfunction

  // Drive one record's inputs.
  task automatic applyStimulus(input vec_t v);
    rst_n     = v.rstN;
    op        = v.op;
    funct3    = v.f3;
    funct7b5  = v.f7b5;
    zero      = v.zero;
    lt        = v.lt;
    ltu       = v.ltu;
    mem_ready = v.memReady;
  endtask

  // Compare the whole output bundle against the expected record.
  task automatic checkOutput(input string name, input logic [18:0] expOut);
    total++;
    if (actOut !== expOut) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, actOut, expOut);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %b want %b", name, act, expv);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RTY  = 7'b0110011;
  localparam logic [6:0] ITY  = 7'b0010011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JL   = 7'b1101111;
  localparam logic [6:0] BADOP = 7'b1111111;

  int seenAt;

  initial begin
    total = 0;
    bad   = 0;

    // Reset and fetch wait states (addi in the IR).
    addVec(0, ITY, 3'b000, 1, 0, 0, 0, 1, stFetch(0, 3'b000));
    addVec(1, ITY, 3'b000, 1, 0, 0, 0, 0, stFetch(0, 3'b000));
    addVec(1, ITY, 3'b000, 1, 0, 0, 0, 0, stFetch(0, 3'b000));
    addVec(1, ITY, 3'b000, 1, 0, 0, 0, 0, stFetch(0, 3'b000));
    addVec(1, ITY, 3'b000, 1, 0, 0, 0, 1, stFetch(1, 3'b000));
    addVec(1, ITY, 3'b000, 1, 0, 0, 0, 1, stDecode(3'b000));
    addVec(1, ITY, 3'b000, 1, 0, 0, 0, 1, stExecI(4'd0, 3'b000));
    addVec(1, ITY, 3'b000, 1, 0, 0, 0, 1, stAluWb(3'b000));
    // lw with memory always ready
    addVec(1, LW, 3'b010, 0, 0, 0, 0, 1, stFetch(1, 3'b000));
    addVec(1, LW, 3'b010, 0, 0, 0, 0, 1, stDecode(3'b000));
    addVec(1, LW, 3'b010, 0, 0, 0, 0, 1, stMemAdr(3'b000));
    addVec(1, LW, 3'b010, 0, 0, 0, 0, 1, stMemRead(3'b000));
    addVec(1, LW, 3'b010, 0, 0, 0, 0, 1, stMemWb(3'b000));
    // sw with mem_ready delayed two cycles
    addVec(1, SW, 3'b010, 0, 0, 0, 0, 1, stFetch(1, 3'b001));
    addVec(1, SW, 3'b010, 0, 0, 0, 0, 1, stDecode(3'b001));
    addVec(1, SW, 3'b010, 0, 0, 0, 0, 0, stMemAdr(3'b001));
    addVec(1, SW, 3'b010, 0, 0, 0, 0, 0, stMemWrite(3'b001));
    addVec(1, SW, 3'b010, 0, 0, 0, 0, 0, stMemWrite(3'b001));
    addVec(1, SW, 3'b010, 0, 0, 0, 0, 1, stMemWrite(3'b001));
    addVec(1, SW, 3'b010, 0, 0, 0, 0, 0, stFetch(0, 3'b001));
    // R-type sub
    addVec(1, RTY, 3'b000, 1, 0, 0, 0, 1, stFetch(1, 3'b000));
    addVec(1, RTY, 3'b000, 1, 0, 0, 0, 1, stDecode(3'b000));
    addVec(1, RTY, 3'b000, 1, 0, 0, 0, 1, stExecR(4'd1, 3'b000));
    addVec(1, RTY, 3'b000, 1, 0, 0, 0, 1, stAluWb(3'b000));
    // srai
    addVec(1, ITY, 3'b101, 1, 0, 0, 0, 1, stFetch(1, 3'b000));
    addVec(1, ITY, 3'b101, 1, 0, 0, 0, 1, stDecode(3'b000));
    addVec(1, ITY, 3'b101, 1, 0, 0, 0, 1, stExecI(4'd9, 3'b000));
    addVec(1, ITY, 3'b101, 1, 0, 0, 0, 1, stAluWb(3'b000));
    // bne taken (zero=0), then not taken (zero=1)
    addVec(1, BR, 3'b001, 0, 0, 0, 0, 1, stFetch(1, 3'b010));
    addVec(1, BR, 3'b001, 0, 0, 0, 0, 1, stDecode(3'b010));
    addVec(1, BR, 3'b001, 0, 0, 0, 0, 1, stBranch(1, 3'b010));
    addVec(1, BR, 3'b001, 0, 1, 0, 0, 1, stFetch(1, 3'b010));
    addVec(1, BR, 3'b001, 0, 1, 0, 0, 1, stDecode(3'b010));
    addVec(1, BR, 3'b001, 0, 1, 0, 0, 1, stBranch(0, 3'b010));
    // bgeu with ltu=1 -> not taken; blt with lt=1 -> taken
    addVec(1, BR, 3'b111, 0, 0, 0, 1, 1, stFetch(1, 3'b010));
    addVec(1, BR, 3'b111, 0, 0, 0, 1, 1, stDecode(3'b010));
    addVec(1, BR, 3'b111, 0, 0, 0, 1, 1, stBranch(0, 3'b010));
    addVec(1, BR, 3'b100, 0, 0, 1, 0, 1, stFetch(1, 3'b010));
    addVec(1, BR, 3'b100, 0, 0, 1, 0, 1, stDecode(3'b010));
    addVec(1, BR, 3'b100, 0, 0, 1, 0, 1, stBranch(1, 3'b010));
    // jal
    addVec(1, JL, 3'b000, 0, 0, 0, 0, 1, stFetch(1, 3'b011));
    addVec(1, JL, 3'b000, 0, 0, 0, 0, 1, stDecode(3'b011));
    addVec(1, JL, 3'b000, 0, 0, 0, 0, 1, stJal(3'b011));
    addVec(1, JL, 3'b000, 0, 0, 0, 0, 1, stAluWb(3'b011));
    // illegal opcode, trap held, then reset clears it
    addVec(1, BADOP, 3'b000, 0, 0, 0, 0, 1, stFetch(1, 3'b000));
    addVec(1, BADOP, 3'b000, 0, 0, 0, 0, 1, stDecode(3'b000));
    addVec(1, BADOP, 3'b000, 0, 0, 0, 0, 1, stTrap(3'b000));
    addVec(1, BADOP, 3'b000, 0, 0, 0, 0, 1, stTrap(3'b000));
    addVec(0, BADOP, 3'b000, 0, 0, 0, 0, 1, stTrap(3'b000));
    addVec(1, BADOP, 3'b000, 0, 0, 0, 0, 0, stFetch(0, 3'b000));

    // Initial reset: two edges with rst_n low.
    rst_n = 1'b0; op = ITY; funct3 = 3'b000; funct7b5 = 1'b0;
    zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b0;
    nextCycle();
    nextCycle();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), vecs[i].expOut);
      nextCycle();
    end

    // Reset in the middle of a store: no write strobe while reset is low,
    // and the FSM restarts at FETCH afterwards.
    op = SW; funct3 = 3'b010; mem_ready = 1'b1; rst_n = 1'b1;
    nextCycle();                      // FETCH -> DECODE
    nextCycle();                      // DECODE -> MEMADR
    mem_ready = 1'b0;
    nextCycle();                      // MEMADR -> MEMWRITE
    @(negedge clk);
    checkBit("sw_memwrite_before_reset", memwrite, 1'b1);
    nextCycle();
    rst_n = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    checkBit("sw_memwrite_in_reset", memwrite, 1'b0);
    checkBit("sw_pcwrite_in_reset", pcwrite, 1'b0);
    nextCycle();
    rst_n = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    checkOutput("fetch_after_midreset", stFetch(0, 3'b001));
    nextCycle();

    // Load whose read waits two cycles on memory: regwrite must show up
    // exactly three cycles after entering MEMREAD, within a bounded wait.
    op = LW; mem_ready = 1'b1;
    nextCycle();                      // FETCH -> DECODE
    nextCycle();                      // DECODE -> MEMADR
    nextCycle();                      // MEMADR -> MEMREAD
    seenAt = -1;
    for (int k = 0; k < 10; k++) begin
      mem_ready = (k >= 2);
      @(negedge clk);
      if (regwrite === 1'b1 && seenAt < 0) begin
        seenAt = k;
        checkBit("lw_wait_resultsrc_b0", resultsrc[0], 1'b1);
      end
      nextCycle();
    end
    total++;
    if (seenAt != 3) begin
      bad++;
      $display("[TB] FAIL lw_wait_regwrite_cycle: got %0d want 3", seenAt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
